// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, transaction
// owner encoding and a small helper for sizing counters.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

    // Bits needed to hold values 0..lim inclusive (never less than one bit).
    function automatic int cnt_width(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Requester selection for the shared memory port. Load/store normally wins;
// after STARVE_LIM back-to-back D grants over a waiting IF, IF is forced.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       grant,
    output arb_owner_t pick
);

    localparam int CW = cnt_width(STARVE_LIM);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [CW-1:0] starve_cnt;

    // Choose the requester to present to memory this cycle.
    always_comb begin
        pick = OWN_NONE;
        if (if_req && (!d_req || starve_cnt == LIM)) begin
            pick = OWN_IF;
        end else if (d_req) begin
            pick = OWN_D;
        end
    end

    // Count D wins while IF is waiting; an IF grant clears the debt.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (pick == OWN_IF) begin
                starve_cnt <= '0;
            end else if (pick == OWN_D && if_req && starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One
// transaction outstanding; the response is routed to its owner, and a
// watchdog completes the transaction with an error if memory stays silent.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t  state;
    arb_state_t  state_next;
    arb_owner_t  owner;
    logic        owner_we;
    logic [WD_W-1:0] wd_cnt;

    arb_owner_t  pick;
    arb_owner_t  sel;
    logic        grant;
    logic        timeout;
    logic        done;

    arb_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .pick   (pick)
    );

    // Next state, memory issue and grants; reset silences every output.
    always_comb begin
        state_next = state;
        sel        = OWN_NONE;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_be       = '0;
        grant      = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        timeout    = 1'b0;
        done       = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!reset) begin
                    sel = pick;
                end
                case (sel)
                    OWN_IF: begin
                        m_req  = 1'b1;
                        m_addr = if_addr;
                        m_be   = {BE_W{1'b1}};
                    end
                    OWN_D: begin
                        m_req   = 1'b1;
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        m_be    = d_be;
                    end
                    default: begin
                    end
                endcase
                grant  = m_req && m_ready;
                if_gnt = grant && (sel == OWN_IF);
                d_gnt  = grant && (sel == OWN_D);
                if (grant) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (!reset) begin
                    timeout = (wd_cnt == WD_LAST);
                    done    = m_rvalid || timeout;
                end
                if (done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Route the completion (real or watchdog) back to the owning requester.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        err       = 1'b0;
        if (done) begin
            err = !m_rvalid;
            if (owner == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = m_rvalid ? m_rdata : '0;
            end else if (owner == OWN_D) begin
                d_rvalid = 1'b1;
                d_rdata  = (m_rvalid && !owner_we) ? m_rdata : '0;
            end
        end
    end

    // State, owner and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner    <= sel;
                owner_we <= (sel == OWN_D) && d_we;
                wd_cnt   <= '0;
            end else if (state == ARB_WAIT) begin
                if (done) begin
                    owner    <= OWN_NONE;
                    owner_we <= 1'b0;
                    wd_cnt   <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    // Protocol invariants: exclusive grants, grants only from IDLE, one outstanding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(if_gnt && d_gnt));
            assert (state == ARB_IDLE || !(if_gnt || d_gnt));
            assert (!(state == ARB_WAIT && m_req));
            assert (!(state == ARB_WAIT && owner == OWN_NONE));
        end
    end

endmodule
